tt_pfd_tristate: RTL and testbench

Parametrised tri-state phase-frequency detector for the PLL loop, successor to the single-cycle pulse PFD. It synchronises the reference and divided-feedback clocks into `i_clk_gen`, runs a classic three-state UP/IDLE/DOWN machine so UP/DOWN width equals the phase error in `i_clk_gen` cycles, and reports a signed per-comparison error, cycle-slip events and a lock indication. It sits between the divider and the digital loop filter / charge-pump driver.

---
 rtl/tt_pfd_pkg.sv | 21 ++
 rtl/tt_pfd_edge_sync.sv | 48 ++++
 rtl/tt_pfd_tristate.sv | 206 ++++++++++++++++++++
 tb/tb_tt_pfd_tristate.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pfd_pkg.sv
// Shared definitions for the tri-state phase-frequency detector.
// Holds the FSM state encoding and the signed-error width helper.
package tt_pfd_pkg;

  typedef enum logic [1:0] {
    PFD_IDLE = 2'd0,
    PFD_UP   = 2'd1,
    PFD_DOWN = 2'd2
  } pfd_state_e;

  // Plain constants so the FSM register can stay a simple logic vector
  localparam logic [1:0] ST_IDLE = PFD_IDLE;
  localparam logic [1:0] ST_UP   = PFD_UP;
  localparam logic [1:0] ST_DOWN = PFD_DOWN;

  // One sign bit on top of the magnitude counter
  function automatic int err_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/tt_pfd_edge_sync.sv
// Input synchroniser plus history flop producing a one-cycle rising-edge pulse.
// With TT_PFD_SCAN_EN the flops double as a scan segment and the edge is gated off.
module tt_pfd_edge_sync
  import tt_pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_gen,
  input  logic i_rst,
  input  logic i_async,
`ifdef TT_PFD_SCAN_EN
  input  logic i_scan_en,
  input  logic i_scan_in,
  output logic o_scan_out,
`endif
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   shift_in;
  logic                   edge_gate;

`ifdef TT_PFD_SCAN_EN
  assign shift_in   = i_scan_en ? i_scan_in : i_async;
  assign edge_gate  = ~i_scan_en;
  assign o_scan_out = hist_q;
`else
  assign shift_in   = i_async;
  assign edge_gate  = 1'b1;
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], shift_in};

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_edge = edge_gate & sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tt_pfd_tristate.sv
// Tri-state PFD: UP/IDLE/DOWN machine, signed phase error, slip strobe and lock.
// Optional scan access through the synchronisers with TT_PFD_SCAN_EN.
module tt_pfd_tristate
  import tt_pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             i_clk_gen,
  input  logic             i_rst,
  input  logic             i_clk_ref,
  input  logic             i_clk_div,
`ifdef TT_PFD_SCAN_EN
  input  logic             i_scan_en,
  input  logic             i_scan_in,
  output logic             o_scan_out,
`endif
  output logic             o_up,
  output logic             o_down,
  output logic [CNT_W:0]   o_phase_err,
  output logic             o_err_valid,
  output logic             o_slip,
  output logic             o_lock
);

  localparam int ERR_W  = err_width(CNT_W);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              ref_edge;
  logic              div_edge;
  logic              scan_hold;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              emit, emit_neg, slip;
  logic [CNT_W-1:0]  emit_mag;
  logic [ERR_W-1:0]  emit_val;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_mag;
  logic              err_valid_q;
  logic              slip_q;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic              lock_q, lock_d;

`ifdef TT_PFD_SCAN_EN
  logic scan_mid;

  tt_pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
    .i_clk_gen  (i_clk_gen),
    .i_rst      (i_rst),
    .i_async    (i_clk_ref),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (i_scan_in),
    .o_scan_out (scan_mid),
    .o_edge     (ref_edge)
  );

  tt_pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_div (
    .i_clk_gen  (i_clk_gen),
    .i_rst      (i_rst),
    .i_async    (i_clk_div),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (scan_mid),
    .o_scan_out (o_scan_out),
    .o_edge     (div_edge)
  );

  assign scan_hold = i_scan_en;
`else
  tt_pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
    .i_clk_gen (i_clk_gen),
    .i_rst     (i_rst),
    .i_async   (i_clk_ref),
    .o_edge    (ref_edge)
  );

  tt_pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_div (
    .i_clk_gen (i_clk_gen),
    .i_rst     (i_rst),
    .i_async   (i_clk_div),
    .o_edge    (div_edge)
  );

  assign scan_hold = 1'b0;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // An edge from the leading input while already waiting is a cycle slip.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_neg = 1'b0;
    emit_mag = '0;
    slip     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_edge && div_edge) begin
          emit = 1'b1;
        end else if (ref_edge) begin
          state_d = ST_UP;
          cnt_d   = CNT_W'(1);
        end else if (div_edge) begin
          state_d = ST_DOWN;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_UP: begin
        if (div_edge) begin
          emit     = 1'b1;
          emit_mag = cnt_q;
          if (ref_edge) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
          slip  = ref_edge;
        end
      end
      ST_DOWN: begin
        if (ref_edge) begin
          emit     = 1'b1;
          emit_neg = 1'b1;
          emit_mag = cnt_q;
          if (div_edge) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
          slip  = div_edge;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign emit_val = emit_neg ? -{1'b0, emit_mag} : {1'b0, emit_mag};

  assign err_mag  = err_q[ERR_W-1] ? (~err_q + ERR_W'(1)) : err_q;
  assign good_inc = (good_q == GOOD_W'(LOCK_CNT)) ? good_q : good_q + GOOD_W'(1);

  // Lock bookkeeping runs off the registered error, one cycle behind the strobe.
  always_comb begin
    good_d = good_q;
    lock_d = lock_q;
    if (slip_q) begin
      good_d = '0;
      lock_d = 1'b0;
    end else if (err_valid_q) begin
      if (err_mag <= ERR_W'(LOCK_TOL)) begin
        good_d = good_inc;
        lock_d = (good_inc == GOOD_W'(LOCK_CNT));
      end else begin
        good_d = '0;
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      good_q      <= '0;
      lock_q      <= 1'b0;
    end else if (scan_hold) begin
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_valid_q <= emit;
      slip_q      <= slip;
      good_q      <= good_d;
      lock_q      <= lock_d;
      if (emit) begin
        err_q <= emit_val;
      end
    end
  end

  assign o_up        = (state_q == ST_UP);
  assign o_down      = (state_q == ST_DOWN);
  assign o_phase_err = err_q;
  assign o_err_valid = err_valid_q;
  assign o_slip      = slip_q;
  assign o_lock      = lock_q;

endmodule

// File: tb/tb_tt_pfd_tristate.sv
// Directed bench for tt_pfd_tristate: default instance plus a CNT_W=4 instance for saturation.
// Scan checks are compiled in only when TT_PFD_SCAN_EN is defined.
module tb_tt_pfd_tristate;

  logic       clk;
  logic       rst;
  logic       ref_i;
  logic       div_i;
  logic       up, down, err_valid, slip, lock;
  logic [8:0] phase_err;
  logic       up4, down4, err_valid4, slip4, lock4;
  logic [4:0] phase_err4;
`ifdef TT_PFD_SCAN_EN
  logic scan_en, scan_in, scan_out, scan_out4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int up_cycles, down_cycles, both_cycles, valid_cnt, slip_cnt;
  int valid_cyc, lock_rise, lock_fall;
  logic [8:0] first_err, last_err;
  logic [4:0] last_err4;
  logic       lock_prev;

  tt_pfd_tristate dut (
    .i_clk_gen   (clk),
    .i_rst       (rst),
    .i_clk_ref   (ref_i),
    .i_clk_div   (div_i),
`ifdef TT_PFD_SCAN_EN
    .i_scan_en   (scan_en),
    .i_scan_in   (scan_in),
    .o_scan_out  (scan_out),
`endif
    .o_up        (up),
    .o_down      (down),
    .o_phase_err (phase_err),
    .o_err_valid (err_valid),
    .o_slip      (slip),
    .o_lock      (lock)
  );

  tt_pfd_tristate #(.CNT_W(4)) dut4 (
    .i_clk_gen   (clk),
    .i_rst       (rst),
    .i_clk_ref   (ref_i),
    .i_clk_div   (div_i),
`ifdef TT_PFD_SCAN_EN
    .i_scan_en   (scan_en),
    .i_scan_in   (scan_in),
    .o_scan_out  (scan_out4),
`endif
    .o_up        (up4),
    .o_down      (down4),
    .o_phase_err (phase_err4),
    .o_err_valid (err_valid4),
    .o_slip      (slip4),
    .o_lock      (lock4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs len cycles; each start index launches a 2-cycle high pulse (-1 = none).
  // Outputs are sampled at the falling edge before the new inputs are applied.
  task automatic run_window(input int r0, input int r1, input int d0, input int d1, input int len);
    up_cycles = 0; down_cycles = 0; both_cycles = 0; valid_cnt = 0; slip_cnt = 0;
    valid_cyc = -1; lock_rise = -1; lock_fall = -1;
    lock_prev = lock;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (up) up_cycles++;
      if (down) down_cycles++;
      if (up && down) both_cycles++;
      if (slip) slip_cnt++;
      if (err_valid) begin
        valid_cnt++;
        if (valid_cnt == 1) first_err = phase_err;
        last_err  = phase_err;
        valid_cyc = c;
      end
      if (err_valid4) last_err4 = phase_err4;
      if (lock && !lock_prev) lock_rise = c;
      if (!lock && lock_prev) lock_fall = c;
      lock_prev = lock;
      ref_i = (r0 >= 0 && c >= r0 && c < r0 + 2) || (r1 >= 0 && c >= r1 && c < r1 + 2);
      div_i = (d0 >= 0 && c >= d0 && c < d0 + 2) || (d1 >= 0 && c >= d1 && c < d1 + 2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (up !== 1'b0) begin n_fail++; $display("FAIL reset_up: got %b expected 0", up); end
    n_checks++; if (down !== 1'b0) begin n_fail++; $display("FAIL reset_down: got %b expected 0", down); end
    n_checks++; if (phase_err !== 9'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", phase_err); end
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", err_valid); end
    n_checks++; if (slip !== 1'b0) begin n_fail++; $display("FAIL reset_slip: got %b expected 0", slip); end
    n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", lock); end
    rst = 1'b0;
  endtask

  task automatic test_ref_leads;
    run_window(0, -1, 5, -1, 14);
    n_checks++; if (up_cycles != 5) begin n_fail++; $display("FAIL ref_leads_up_width: got %0d expected 5", up_cycles); end
    n_checks++; if (down_cycles != 0) begin n_fail++; $display("FAIL ref_leads_down: got %0d expected 0", down_cycles); end
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("FAIL ref_leads_valid_cnt: got %0d expected 1", valid_cnt); end
    n_checks++; if (last_err !== 9'd5) begin n_fail++; $display("FAIL ref_leads_err: got %0d expected 5", $signed(last_err)); end
    n_checks++; if (valid_cyc != 8) begin n_fail++; $display("FAIL ref_leads_valid_cycle: got %0d expected 8", valid_cyc); end
  endtask

  task automatic test_div_leads;
    run_window(3, -1, 0, -1, 12);
    n_checks++; if (down_cycles != 3) begin n_fail++; $display("FAIL div_leads_down_width: got %0d expected 3", down_cycles); end
    n_checks++; if (up_cycles != 0) begin n_fail++; $display("FAIL div_leads_up: got %0d expected 0", up_cycles); end
    n_checks++; if (last_err !== 9'h1FD) begin n_fail++; $display("FAIL div_leads_err: got %0d expected -3", $signed(last_err)); end
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("FAIL div_leads_valid_cnt: got %0d expected 1", valid_cnt); end
  endtask

  task automatic test_simultaneous;
    run_window(0, -1, 0, -1, 8);
    n_checks++; if (up_cycles + down_cycles != 0) begin n_fail++; $display("FAIL simul_updown: got %0d expected 0", up_cycles + down_cycles); end
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("FAIL simul_valid_cnt: got %0d expected 1", valid_cnt); end
    n_checks++; if (last_err !== 9'd0) begin n_fail++; $display("FAIL simul_err: got %0d expected 0", $signed(last_err)); end
  endtask

  task automatic test_both_in_up;
    run_window(0, 6, 6, 9, 16);
    n_checks++; if (valid_cnt != 2) begin n_fail++; $display("FAIL both_up_valid_cnt: got %0d expected 2", valid_cnt); end
    n_checks++; if (first_err !== 9'd6) begin n_fail++; $display("FAIL both_up_first_err: got %0d expected 6", $signed(first_err)); end
    n_checks++; if (last_err !== 9'd3) begin n_fail++; $display("FAIL both_up_restart_err: got %0d expected 3", $signed(last_err)); end
    n_checks++; if (up_cycles != 9) begin n_fail++; $display("FAIL both_up_width: got %0d expected 9", up_cycles); end
    n_checks++; if (both_cycles != 0) begin n_fail++; $display("FAIL both_up_exclusive: got %0d expected 0", both_cycles); end
  endtask

  task automatic test_slip;
    run_window(0, 6, 12, -1, 20);
    n_checks++; if (slip_cnt != 1) begin n_fail++; $display("FAIL slip_cnt: got %0d expected 1", slip_cnt); end
    n_checks++; if (last_err !== 9'd12) begin n_fail++; $display("FAIL slip_err: got %0d expected 12", $signed(last_err)); end
    n_checks++; if (up_cycles != 12) begin n_fail++; $display("FAIL slip_up_width: got %0d expected 12", up_cycles); end
  endtask

  task automatic test_saturation;
    run_window(0, -1, 40, -1, 48);
    n_checks++; if (last_err !== 9'd40) begin n_fail++; $display("FAIL sat_err_w8: got %0d expected 40", $signed(last_err)); end
    n_checks++; if (last_err4 !== 5'd15) begin n_fail++; $display("FAIL sat_err_w4: got %0d expected 15", $signed(last_err4)); end
  endtask

  task automatic test_lock;
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) run_window(0, -1, 2, -1, 8);
      else            run_window(2, -1, 0, -1, 8);
    end
    n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_after_15: got %b expected 0", lock); end
    run_window(2, -1, 0, -1, 8);
    n_checks++; if (last_err !== 9'h1FE) begin n_fail++; $display("FAIL lock_16th_err: got %0d expected -2", $signed(last_err)); end
    n_checks++; if (lock_rise != valid_cyc + 1 || valid_cyc < 0) begin n_fail++; $display("FAIL lock_rise: got cycle %0d expected %0d", lock_rise, valid_cyc + 1); end
    run_window(0, -1, 3, -1, 8);
    n_checks++; if (last_err !== 9'd3) begin n_fail++; $display("FAIL unlock_err: got %0d expected 3", $signed(last_err)); end
    n_checks++; if (lock_fall != valid_cyc + 1 || valid_cyc < 0) begin n_fail++; $display("FAIL lock_fall: got cycle %0d expected %0d", lock_fall, valid_cyc + 1); end
  endtask

  task automatic test_reset_mid_up;
    @(negedge clk);
    ref_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (up !== 1'b1) begin n_fail++; $display("FAIL midup_pre_up: got %b expected 1", up); end
    rst = 1'b1;
    ref_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({up, down, err_valid, slip, lock} !== 5'b0) begin n_fail++; $display("FAIL midup_flags: got %b expected 00000", {up, down, err_valid, slip, lock}); end
    n_checks++; if (phase_err !== 9'd0) begin n_fail++; $display("FAIL midup_err: got %0d expected 0", $signed(phase_err)); end
    rst = 1'b0;
    run_window(-1, -1, -1, -1, 10);
    n_checks++; if (valid_cnt + up_cycles != 0) begin n_fail++; $display("FAIL midup_no_emit: got %0d expected 0", valid_cnt + up_cycles); end
  endtask

`ifdef TT_PFD_SCAN_EN
  task automatic test_scan;
    logic [13:0] pat;
    int          vcount;
    int          upcount;
    pat = 14'b01001101_101101;
    vcount = 0;
    upcount = 0;
    @(negedge clk);
    ref_i = 1'b1;
    repeat (3) @(negedge clk);
    scan_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (err_valid) vcount++;
      if (up) upcount++;
      if (c >= 6) begin
        n_checks++;
        if (scan_out !== pat[c-6]) begin n_fail++; $display("FAIL scan_out_bit%0d: got %b expected %b", c - 6, scan_out, pat[c-6]); end
      end
      scan_in = pat[c];
    end
    n_checks++; if (upcount != 14) begin n_fail++; $display("FAIL scan_fsm_hold: got %0d expected 14", upcount); end
    n_checks++; if (vcount != 0) begin n_fail++; $display("FAIL scan_no_emit: got %0d expected 0", vcount); end
    scan_en = 1'b0;
    ref_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    ref_i = 1'b0;
    div_i = 1'b0;
    first_err = '0;
    last_err = '0;
    last_err4 = '0;
`ifdef TT_PFD_SCAN_EN
    scan_en = 1'b0;
    scan_in = 1'b0;
`endif
    test_reset();
    test_ref_leads();
    test_div_leads();
    test_simultaneous();
    test_both_in_up();
    test_slip();
    test_saturation();
    test_lock();
    test_reset_mid_up();
`ifdef TT_PFD_SCAN_EN
    test_scan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
